// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: PC source select,
// offset update select, FSM states and the interrupt index width.
package pc_seq_pkg;

  // PC source select codes; codes 3 and 9-15 are unused and behave as hold
  typedef enum logic [3:0] {
    PC_HOLD  = 4'd0,
    PC_INCR  = 4'd1,
    PC_RST   = 4'd2,
    PC_ZERO  = 4'd4,
    PC_IMM16 = 4'd5,
    PC_REL8  = 4'd6,
    PC_REG   = 4'd7,
    PC_INT   = 4'd8
  } pc_sel_e;

  // Offset update select codes; code 3 behaves as hold
  typedef enum logic [1:0] {
    OFF_HOLD = 2'd0,
    OFF_INCR = 2'd1,
    OFF_ZERO = 2'd2
  } offset_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } state_e;

  // Interrupt index width, large enough for up to 8 request lines
  localparam int INT_IDX_W = 3;

endpackage

// File: rtl/pc_int_prio_enc.sv
// Fixed-priority interrupt encoder: bit 0 is the highest priority.
// Produces a valid flag, the binary index of the winner and a one-hot grant.
module pc_int_prio_enc
  import pc_seq_pkg::*;
#(
  parameter int NUM_INT = 5
) (
  input  logic [NUM_INT-1:0]   req,
  output logic                 valid,
  output logic [INT_IDX_W-1:0] idx,
  output logic [NUM_INT-1:0]   grant
);

  // Scan from the lowest-priority line down so the lowest set index wins
  always_comb begin
    valid = |req;
    idx   = '0;
    grant = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx      = INT_IDX_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with fetch offset, operand buffer, interrupt
// dispatch and HALT handling. Synchronous active-low reset.
// Optional feature macro: PC_SEQ_HALT_BUG_EN -- after waking from HALT with
// ime=0, the first INCR leaves pc unchanged once.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W          = 16,
  parameter int                OFFSET_W        = 2,
  parameter int                NUM_INT         = 5,
  parameter logic [ADDR_W-1:0] RESET_PC        = 'h100,
  parameter logic [ADDR_W-1:0] INT_BASE        = 'h40,
  parameter int                INT_STRIDE_LOG2 = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [3:0]         pc_sel,
  input  logic [1:0]         offset_sel,
  input  logic [7:0]         data_bus,
  input  logic               write_temp_buf,
  input  logic [ADDR_W-1:0]  reg_file_in,
  input  logic [2:0]         rst_pc_in,
  input  logic [NUM_INT-1:0] int_req,
  input  logic               ime,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_w_offset,
  output logic [NUM_INT-1:0] int_ack,
  output logic               halted
);

  state_e                state, state_nxt;
  logic [OFFSET_W-1:0]   offset, offset_nxt;
  logic [7:0]            temp_buf, buf_nxt;
  logic [ADDR_W-1:0]     pc_nxt;
  logic [NUM_INT-1:0]    ack_nxt;
  logic                  req_valid;
  logic [INT_IDX_W-1:0]  req_idx;
  logic [NUM_INT-1:0]    req_grant;
  logic [ADDR_W-1:0]     int_vec;

`ifdef PC_SEQ_HALT_BUG_EN
  logic                  halt_bug, halt_bug_nxt;
`else
  logic                  ime_unused;
  assign ime_unused = ime;
`endif

  pc_int_prio_enc #(.NUM_INT(NUM_INT)) u_prio (
    .req   (int_req),
    .valid (req_valid),
    .idx   (req_idx),
    .grant (req_grant)
  );

  assign pc_w_offset = pc + ADDR_W'(offset);
  assign int_vec     = INT_BASE + (ADDR_W'(req_idx) << INT_STRIDE_LOG2);
  assign halted      = (state == ST_HALT);

  // Next-state and datapath selection; stall freezes everything and drops any ack
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    offset_nxt = offset;
    buf_nxt    = temp_buf;
    ack_nxt    = '0;
`ifdef PC_SEQ_HALT_BUG_EN
    halt_bug_nxt = halt_bug;
`endif
    if (!stall) begin
      case (state)
        ST_RUN: begin
          if (write_temp_buf) buf_nxt = data_bus;
          case (offset_sel)
            OFF_INCR: offset_nxt = offset + OFFSET_W'(1);
            OFF_ZERO: offset_nxt = '0;
            default:  offset_nxt = offset;
          endcase
          case (pc_sel)
            PC_INCR: begin
`ifdef PC_SEQ_HALT_BUG_EN
              if (halt_bug) halt_bug_nxt = 1'b0;
              else          pc_nxt = pc_w_offset + ADDR_W'(1);
`else
              pc_nxt = pc_w_offset + ADDR_W'(1);
`endif
            end
            PC_RST:   pc_nxt = ADDR_W'({rst_pc_in, 3'b000});
            PC_ZERO:  pc_nxt = '0;
            PC_IMM16: pc_nxt = ADDR_W'({data_bus, temp_buf});
            PC_REL8:  pc_nxt = pc_w_offset + ADDR_W'($signed(data_bus));
            PC_REG:   pc_nxt = reg_file_in;
            PC_INT: begin
              if (req_valid) begin
                pc_nxt     = int_vec;
                offset_nxt = '0;
                ack_nxt    = req_grant;
                state_nxt  = ST_DISPATCH;
              end
            end
            default:  pc_nxt = pc;
          endcase
          if (halt_req && !req_valid) state_nxt = ST_HALT;
        end
        ST_HALT: begin
          if (req_valid) begin
            state_nxt = ST_RUN;
`ifdef PC_SEQ_HALT_BUG_EN
            if (!ime) halt_bug_nxt = 1'b1;
`endif
          end
        end
        ST_DISPATCH: begin
          if (write_temp_buf) buf_nxt = data_bus;
          state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      offset   <= '0;
      temp_buf <= '0;
      int_ack  <= '0;
`ifdef PC_SEQ_HALT_BUG_EN
      halt_bug <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      offset   <= offset_nxt;
      temp_buf <= buf_nxt;
      int_ack  <= ack_nxt;
`ifdef PC_SEQ_HALT_BUG_EN
      halt_bug <= halt_bug_nxt;
`endif
    end
  end

endmodule
